frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_JOBS, default 3, number of per-frame SDRAM jobs sequenced (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 833333, max clk cycles one job may run (one 60 Hz frame at 50 MHz).
REQ-003 SHALL have parameter CNT_W, default 8, width of dropped-frame counter.
REQ-004 SHALL have port clk, input, 1, system clock (MAX10_CLK1_50 domain).
REQ-005 SHALL have port reset_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port new_frame, input, 1, frame-boundary pulse from pixel_clk domain, asynchronous to clk.
REQ-007 SHALL have port init_done, input, 1, level-high once SD-card/memory preload is complete.
REQ-008 SHALL have port job_start, output, NUM_JOBS, one-cycle start pulse per job.
REQ-009 SHALL have port job_done, input, NUM_JOBS, one-cycle completion pulse per job.
REQ-010 SHALL have port job_abort, output, NUM_JOBS, one-cycle abort pulse on timeout.
REQ-011 SHALL have port frame_flip, output, 1, double-buffer select toggled at frame boundary.
REQ-012 SHALL have port busy, output, 1, high while any job is started or running.
REQ-013 SHALL have port dropped_frames, output, CNT_W, count of frame boundaries arriving while busy.
REQ-014 SHALL have port timeout_err, output, NUM_JOBS, sticky per-job timeout flags.

Function
REQ-015 SHALL synchronize new_frame with a 2-flop synchronizer and detect its rising edge (frame_evt), latency 3 clk cycles from input rise.
REQ-016 SHALL implement states INIT, WAIT_FRAME, START, RUN, NEXT.
REQ-017 INIT: SHALL hold all outputs at reset value until init_done=1, then go to WAIT_FRAME; frame_evt ignored in INIT.
REQ-018 WAIT_FRAME: on frame_evt, SHALL toggle frame_flip if pending_flip=1, clear pending_flip, set job index to 0, go to START.
REQ-019 START: SHALL assert job_start[idx] for exactly one cycle, clear the timeout counter, go to RUN.
REQ-020 RUN: on job_done[idx] SHALL go to NEXT; job_done bits for other indices SHALL be ignored.
REQ-021 NEXT: if idx=NUM_JOBS-1 SHALL set pending_flip and go to WAIT_FRAME, else increment idx and go to START.
REQ-022 frame_evt in START, RUN or NEXT SHALL increment dropped_frames (saturating at 2^CNT_W-1) and SHALL NOT restart the sequence or toggle frame_flip.
REQ-023 job_done[idx] and frame_evt in the same RUN cycle SHALL both take effect: advance and count one drop.
REQ-024 busy SHALL be 1 exactly in START, RUN, NEXT.
REQ-025 If a sequence ended with any aborted job, pending_flip SHALL still be set (frame displayed even if partial).

Reset
REQ-026 On reset_n=0, asynchronously: state=INIT, idx=0, frame_flip=0, pending_flip=0, job_start=0, job_abort=0, busy=0, dropped_frames=0, timeout_err=0, synchronizer flops=0.
REQ-027 Reset asserted mid-job SHALL drop the sequence without an abort pulse; sequencing restarts only after init_done and a fresh frame_evt.

Configuration
REQ-028 With FRAME_SEQ_TIMEOUT_EN defined: in RUN, a counter SHALL increment each cycle; on reaching TIMEOUT_CYC-1 without job_done, SHALL pulse job_abort[idx] one cycle, set timeout_err[idx], go to NEXT.
REQ-029 Without FRAME_SEQ_TIMEOUT_EN: no timeout counter, job_abort tied 0, timeout_err tied 0, RUN waits indefinitely for job_done.

Structure
REQ-030 Shared package rhythm_pkg SHALL hold the state enum type frame_seq_state_t and constant FRAME_CYC_50M=833333.
REQ-031 Synchronizer plus edge detect SHALL be sub-module pulse_sync (input async level, output one-cycle clk pulse); all other logic SHALL be in frame_sequencer.

Verification
REQ-032 Reset, init_done=0, 5 frame pulses -> no job_start, frame_flip=0, dropped_frames=0.
REQ-033 init_done=1, frame pulse, each job returns done 100 cycles after start -> job_start[0],[1],[2] in order, busy falls after job 2 done, frame_flip=0 until next frame pulse, then 1.
REQ-034 Job 1 done delayed past two frame pulses -> dropped_frames=2, no extra job_start[0], flip occurs at third pulse.
REQ-035 FRAME_SEQ_TIMEOUT_EN, TIMEOUT_CYC=50, job 0 never done -> job_abort[0] pulse at cycle 50 after start, timeout_err=3'b001, job_start[1] follows.
REQ-036 reset_n low during RUN of job 1 -> all outputs at reset values immediately, no job_abort, next job_start[0] only after following frame pulse.
REQ-037 dropped_frames at 255 (CNT_W=8) plus another overlapping frame pulse -> stays 255.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the frame sequencing logic.
package rhythm_pkg;

  typedef enum logic [2:0] {
    INIT,
    WAIT_FRAME,
    START,
    RUN,
    NEXT
  } frame_seq_state_t;

  localparam int FRAME_CYC_50M = 833333;

endpackage

// File: rtl/frame_sequencer_pulse_sync.sv
// pulse_sync: two-flop synchronizer for an asynchronous level, followed by a
// registered rising-edge detector producing a one-cycle pulse in clk.
module pulse_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      // edge detect registered so the pulse lands three clocks after the input rise
      sync_p2 <= sync_p1;
      pulse   <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame SDRAM job sequencer with double-buffer flip and dropped-frame count.
// Optional per-job watchdog enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_sequencer
  import rhythm_pkg::*;
#(
  parameter int NUM_JOBS    = 3,
  parameter int TIMEOUT_CYC = FRAME_CYC_50M,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                new_frame,
  input  logic                init_done,
  output logic [NUM_JOBS-1:0] job_start,
  input  logic [NUM_JOBS-1:0] job_done,
  output logic [NUM_JOBS-1:0] job_abort,
  output logic                frame_flip,
  output logic                busy,
  output logic [CNT_W-1:0]    dropped_frames,
  output logic [NUM_JOBS-1:0] timeout_err
);

  localparam int IDX_W = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_JOBS - 1);

  frame_seq_state_t state;
  logic [IDX_W-1:0] idx;
  logic             pending_flip;
  logic             frame_evt;
  logic             timeout_hit;
  logic             seq_active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [NUM_JOBS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_JOBS-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  pulse_sync u_frame_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_in(new_frame),
    .pulse   (frame_evt)
  );

  assign seq_active = (state == START) || (state == RUN) || (state == NEXT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT;
      idx            <= '0;
      frame_flip     <= 1'b0;
      pending_flip   <= 1'b0;
      job_start      <= '0;
      busy           <= 1'b0;
      dropped_frames <= '0;
    end else begin
      job_start <= '0;
      // frames arriving mid-sequence are only counted, never restart it
      if (frame_evt && seq_active)
        dropped_frames <= sat_inc(dropped_frames);
      case (state)
        INIT: begin
          if (init_done) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (frame_evt) begin
            if (pending_flip) frame_flip <= ~frame_flip;
            pending_flip <= 1'b0;
            idx          <= '0;
            job_start    <= onehot('0);
            busy         <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (job_done[idx] || timeout_hit) state <= NEXT;
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            // aborted jobs still leave a frame to show, so the flip is always armed
            pending_flip <= 1'b1;
            busy         <= 1'b0;
            state        <= WAIT_FRAME;
          end else begin
            idx       <= idx + 1'b1;
            job_start <= onehot(idx + 1'b1);
            state     <= START;
          end
        end
        default: begin
          state <= INIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr;

  // abort fires as the counter steps onto TIMEOUT_CYC-1; a same-cycle done wins
  assign timeout_hit = (state == RUN) && !job_done[idx] &&
                       ((tmr + 1'b1) == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr         <= '0;
      job_abort   <= '0;
      timeout_err <= '0;
    end else begin
      job_abort <= '0;
      if (state == START)
        tmr <= '0;
      else if (state == RUN)
        tmr <= tmr + 1'b1;
      if (timeout_hit) begin
        job_abort   <= onehot(idx);
        timeout_err <= timeout_err | onehot(idx);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign job_abort   = '0;
  assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboarded bench for frame_sequencer: expected job starts are queued as frames
// are driven and consumed as the DUT pulses job_start.
module tb_frame_sequencer;

  localparam int NJ = 3;
  localparam int CW = 8;
  localparam int JD = 100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          new_frame = 1'b0;
  logic          init_done = 1'b0;
  logic [NJ-1:0] job_done = '0;
  logic [NJ-1:0] job_start;
  logic [NJ-1:0] job_abort;
  logic          frame_flip;
  logic          busy;
  logic [CW-1:0] dropped_frames;
  logic [NJ-1:0] timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_start_q[$];
  int exp_abort_q[$];
  int seen_start[NJ] = '{default: 0};
  int done_delay[NJ] = '{default: JD};
  int last_done_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_sequencer #(.NUM_JOBS(NJ), .TIMEOUT_CYC(10000), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .new_frame     (new_frame),
    .init_done     (init_done),
    .job_start     (job_start),
    .job_done      (job_done),
    .job_abort     (job_abort),
    .frame_flip    (frame_flip),
    .busy          (busy),
    .dropped_frames(dropped_frames),
    .timeout_err   (timeout_err)
  );

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic          new_frame2 = 1'b0;
  logic [NJ-1:0] job_done2 = '0;
  logic [NJ-1:0] job_start2, job_abort2, timeout_err2;
  logic          frame_flip2, busy2;
  logic [CW-1:0] dropped2;

  frame_sequencer #(.NUM_JOBS(NJ), .TIMEOUT_CYC(50), .CNT_W(CW)) dut_to (
    .clk           (clk),
    .reset_n       (reset_n),
    .new_frame     (new_frame2),
    .init_done     (init_done),
    .job_start     (job_start2),
    .job_done      (job_done2),
    .job_abort     (job_abort2),
    .frame_flip    (frame_flip2),
    .busy          (busy2),
    .dropped_frames(dropped2),
    .timeout_err   (timeout_err2)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every start/abort pulse must match the head of its queue
  always @(negedge clk) begin
    int e;
    if (job_start != '0) begin
      if (exp_start_q.size() == 0) check_eq("unexpected_start", 32'(job_start), 0);
      else begin
        e = exp_start_q.pop_front();
        check_eq("job_start_order", 32'(job_start), 32'(1 << e));
      end
      for (int i = 0; i < NJ; i++) if (job_start[i]) seen_start[i]++;
    end
    if (job_abort != '0) begin
      if (exp_abort_q.size() == 0) check_eq("unexpected_abort", 32'(job_abort), 0);
      else begin
        e = exp_abort_q.pop_front();
        check_eq("job_abort_order", 32'(job_abort), 32'(1 << e));
      end
    end
  end

  // Job model: answer each start with a done pulse after done_delay cycles (0 = never)
  initial begin
    int j;
    forever begin
      @(negedge clk);
      if (job_start != '0) begin
        j = 0;
        for (int i = 0; i < NJ; i++) if (job_start[i]) j = i;
        if (done_delay[j] > 0) begin
          repeat (done_delay[j]) @(posedge clk);
          #1 job_done[j] = 1'b1;
          last_done_cyc = cyc;
          @(posedge clk);
          #1 job_done[j] = 1'b0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  task automatic frame_pulse();
    @(posedge clk);
    #1 new_frame = 1'b1;
    repeat (4) @(posedge clk);
    #1 new_frame = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic push_jobs(input int n);
    for (int i = 0; i < n; i++) exp_start_q.push_back(i);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy === lvl) return;
    end
    check_eq(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_start(input int j, input int prev, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (seen_start[j] > prev) return;
    end
    check_eq(tag, 32'(seen_start[j]), 32'(prev + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_job_start"}, 32'(job_start), 0);
    check_eq({tag, "_job_abort"}, 32'(job_abort), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_flip"}, 32'(frame_flip), 0);
    check_eq({tag, "_dropped"}, 32'(dropped_frames), 0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    int s0, s1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // frames before init_done are ignored
    repeat (5) frame_pulse();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("init_no_start", 32'(seen_start[0]), 0);
    check_eq("init_flip", 32'(frame_flip), 0);
    check_eq("init_dropped", 32'(dropped_frames), 0);
    check_eq("init_busy", 32'(busy), 0);

    // first full sequence
    init_done = 1'b1;
    repeat (3) @(posedge clk);
    push_jobs(NJ);
    frame_pulse();
    wait_busy(1'b0, 1000, "seq1_end");
    check_eq("busy_fall_after_last_done", 32'(cyc - last_done_cyc), 2);
    check_eq("seq1_all_started", 32'(exp_start_q.size()), 0);
    check_eq("seq1_flip", 32'(frame_flip), 0);
    check_eq("seq1_dropped", 32'(dropped_frames), 0);

    push_jobs(NJ);
    frame_pulse();
    check_eq("seq2_flip", 32'(frame_flip), 1);
    wait_busy(1'b0, 1000, "seq2_end");

    // job 1 stalls across two frames: both counted, no restart, no flip
    done_delay[1] = 300;
    push_jobs(NJ);
    s1 = seen_start[1];
    frame_pulse();
    check_eq("seq3_flip", 32'(frame_flip), 0);
    wait_start(1, s1, 300, "seq3_job1_start");
    frame_pulse();
    frame_pulse();
    check_eq("overlap_dropped", 32'(dropped_frames), 2);
    check_eq("overlap_no_flip", 32'(frame_flip), 0);
    wait_busy(1'b0, 1000, "seq3_end");
    check_eq("seq3_no_extra_start", 32'(exp_start_q.size()), 0);
    done_delay[1] = JD;
    push_jobs(NJ);
    frame_pulse();
    check_eq("flip_after_overlap", 32'(frame_flip), 1);
    wait_busy(1'b0, 1000, "seq4_end");

    // reset during job 1 drops everything without an abort
    done_delay[1] = 200;
    exp_start_q.push_back(0);
    exp_start_q.push_back(1);
    s1 = seen_start[1];
    frame_pulse();
    wait_start(1, s1, 300, "seq5_job1_start");
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midjob_reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    s0 = seen_start[0];
    repeat (300) @(posedge clk);
    @(negedge clk);
    check_eq("no_restart_without_frame", 32'(seen_start[0]), 32'(s0));
    check_eq("reset_busy_idle", 32'(busy), 0);
    done_delay[1] = JD;
    push_jobs(NJ);
    frame_pulse();
    check_eq("restart_job0", 32'(seen_start[0]), 32'(s0 + 1));
    wait_busy(1'b0, 1000, "seq6_end");

    // saturate the dropped-frame counter
    done_delay[0] = 5000;
    push_jobs(NJ);
    s0 = seen_start[0];
    frame_pulse();
    wait_start(0, s0, 50, "seq7_job0_start");
    repeat (255) frame_pulse();
    check_eq("dropped_at_max", 32'(dropped_frames), 255);
    frame_pulse();
    check_eq("dropped_saturated", 32'(dropped_frames), 255);
    wait_busy(1'b0, 6000, "seq7_end");
    done_delay[0] = JD;
    check_eq("final_timeout_err", 32'(timeout_err), 0);
    check_eq("final_queue_empty", 32'(exp_start_q.size()), 0);

`ifdef FRAME_SEQ_TIMEOUT_EN
    begin
      int t_s, t_a;
      t_s = -1;
      t_a = -1;
      @(posedge clk);
      #1 new_frame2 = 1'b1;
      for (int k = 0; k < 100 && t_s < 0; k++) begin
        @(negedge clk);
        if (job_start2[0]) t_s = cyc;
      end
      #1 new_frame2 = 1'b0;
      for (int k = 0; k < 100 && t_a < 0; k++) begin
        @(negedge clk);
        if (job_abort2 != '0) begin
          t_a = cyc;
          check_eq("to_abort_idx", 32'(job_abort2), 1);
          check_eq("to_timeout_err", 32'(timeout_err2), 1);
        end
      end
      check_eq("to_abort_latency", 32'(t_a - t_s), 50);
      @(negedge clk);
      check_eq("to_next_start", 32'(job_start2), 2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
